snake_dir_ctrl: RTL and testbench
=================================

SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of stable synchronised samples needed to accept a key level change (250000 on the board build).
REQ-002 The block SHALL have parameter KEY_ACTIVE_LOW, default 1; when 1, KEY=0 means pressed.
REQ-003 The block SHALL have input CLOCK_50, 1 bit: the single system clock; all logic is rising-edge triggered.
REQ-004 The block SHALL have input Reset, 1 bit: synchronous, active-high.
REQ-005 The block SHALL have input KEY, 4 bits: raw asynchronous pushbuttons; KEY[0]=right, KEY[1]=down, KEY[2]=up, KEY[3]=left.
REQ-006 The block SHALL have input tick, 1 bit: one-cycle game-step strobe from the snake mover.
REQ-007 The block SHALL have output dir, 2 bits: current heading; 00 up, 01 down, 10 left, 11 right.
REQ-008 The block SHALL have output dir_changed, 1 bit: one-cycle pulse when dir changes value.
REQ-009 The block SHALL have output q_count, 2 bits: number of queued turn commands (0..2).
REQ-010 The block SHALL have output drop, 1 bit: one-cycle pulse when a press is discarded.

Function
REQ-011 Each KEY bit SHALL pass through a 2-flop synchroniser and be normalised to pressed=1 per KEY_ACTIVE_LOW.
REQ-012 Each key SHALL have its own debounce counter; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive synchronised samples differ from it; any matching sample clears the counter.
REQ-013 A press event SHALL be a debounced 0->1 transition; a release SHALL generate no event.
REQ-014 A press event SHALL reach q_count exactly DEBOUNCE_CYCLES+3 cycles after the first clock edge at which the raw KEY shows the new level.
REQ-015 If press events occur for several keys in the same cycle, only the lowest-index key SHALL be processed; the rest SHALL be discarded and drop SHALL pulse.
REQ-016 The block SHALL hold a 2-entry FIFO of directions; the reference direction is the FIFO tail, or dir if the FIFO is empty.
REQ-017 A press SHALL be discarded with drop=1 when its direction equals the reference direction or is its reversal (bit0 flipped, bit1 equal).
REQ-018 A press SHALL be discarded with drop=1 when the FIFO holds 2 entries and no pop occurs in the same cycle.
REQ-019 When none of the discard conditions apply, the press SHALL be appended to the FIFO.
REQ-020 On tick with a non-empty FIFO, the head SHALL be popped into dir on the next edge and dir_changed SHALL pulse in that same cycle.
REQ-021 On tick with an empty FIFO, dir SHALL remain unchanged and dir_changed SHALL stay 0.
REQ-022 When tick and a press occur in the same cycle, the pop SHALL occur first; the reference for REQ-017 SHALL be the post-pop tail, or the new dir if the FIFO becomes empty; the push SHALL then succeed even if the FIFO was full.
REQ-023 q_count SHALL never exceed 2 and SHALL never wrap.
REQ-024 drop and dir_changed SHALL be registered and SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-025 While Reset=1 at a clock edge, the block SHALL set dir=11 (right), clear the FIFO (q_count=0), set dir_changed=0 and drop=0, clear the debounced levels and counters to released, and clear the synchroniser flops to released.
REQ-026 Reset asserted mid-debounce or with queued commands SHALL discard all pending state.
REQ-027 After Reset, a key held through reset SHALL be re-debounced; it yields one press event DEBOUNCE_CYCLES+3 cycles after release of Reset.

Verification
REQ-028 Scenario: after reset, press KEY[2] (up) for 10 cycles, then tick -> q_count=1 at cycle 7 after the edge; after tick, dir=00, dir_changed pulses once, q_count=0.
REQ-029 Scenario: dir=11, press KEY[3] (left) -> drop pulses, q_count stays 0, dir stays 11; press KEY[0] (right) -> drop pulses (duplicate).
REQ-030 Scenario: KEY glitch pressed for 3 cycles with DEBOUNCE_CYCLES=4 -> no event, q_count=0, drop=0.
REQ-031 Scenario: with dir=11, press up, then left, then down with no tick -> queue holds {up,left}, q_count=2, and down gives a drop pulse; two ticks -> dir becomes 00 then 10.
REQ-032 Scenario: FIFO full {up,left}, a down press coincides with tick -> dir=00, queue {left,down}, q_count=2, no drop.
REQ-033 Scenario: KEY[0] and KEY[2] pressed on the same edge (dir=01) -> right is queued, up is dropped with one drop pulse; Reset asserted with q_count=1 -> dir=11 and q_count=0 on the next edge.

Source files
------------

// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: synchronises and debounces four pushbuttons, turns
// presses into turn commands, and queues up to two of them for the game tick.
module snake_dir_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter bit          KEY_ACTIVE_LOW  = 1
) (
   input  logic       CLOCK_50,
   input  logic       Reset,
   input  logic [3:0] KEY,
   input  logic       tick,
   output logic [1:0] dir,
   output logic       dir_changed,
   output logic [1:0] q_count,
   output logic       drop
);

   localparam int unsigned   CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]    RELEASED = KEY_ACTIVE_LOW ? 4'b1111 : 4'b0000;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   logic [3:0]    sync1, sync2;
   logic [3:0]    key_level;
   logic [3:0]    deb, deb_prev, press_r;
   logic [CW-1:0] cnt [4];

   dir_t       dir_r, q0, q1;
   logic [1:0] cnt_q;

   dir_t       sel_dir, dir_n, h0, ref_dir, rev_dir, q0_n, q1_n;
   logic       sel_valid, extra, pop, reject, push, drop_n;
   logic [1:0] cnt_p, cnt_n;

   // Normalise after the synchroniser so no logic sits ahead of the first flop.
   assign key_level = KEY_ACTIVE_LOW ? ~sync2 : sync2;

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         sync1    <= RELEASED;
         sync2    <= RELEASED;
         deb      <= '0;
         deb_prev <= '0;
         press_r  <= '0;
         for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         sync1    <= KEY;
         sync2    <= sync1;
         deb_prev <= deb;
         press_r  <= deb & ~deb_prev;
         for (int unsigned i = 0; i < 4; i++) begin
            if (key_level[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= key_level[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   always_comb begin
      sel_valid = 1'b1;
      sel_dir   = DIR_RIGHT;
      if (press_r[0])      sel_dir = DIR_RIGHT;
      else if (press_r[1]) sel_dir = DIR_DOWN;
      else if (press_r[2]) sel_dir = DIR_UP;
      else if (press_r[3]) sel_dir = DIR_LEFT;
      else                 sel_valid = 1'b0;
      extra = (press_r & (press_r - 4'd1)) != 4'd0;

      // Pop is resolved first so a same-cycle press is judged against the post-pop queue.
      pop   = tick && (cnt_q != 2'd0);
      dir_n = pop ? q0 : dir_r;
      h0    = pop ? q1 : q0;
      cnt_p = cnt_q - 2'(pop);

      ref_dir = q1;
      if (cnt_p == 2'd0)      ref_dir = dir_n;
      else if (cnt_p == 2'd1) ref_dir = h0;
      rev_dir = dir_t'({ref_dir[1], ~ref_dir[0]});

      reject = (sel_dir == ref_dir) || (sel_dir == rev_dir);
      push   = sel_valid && !reject && (cnt_p != 2'd2);
      drop_n = extra || (sel_valid && !push);

      q0_n = h0;
      q1_n = q1;
      if (push) begin
         if (cnt_p == 2'd0) q0_n = sel_dir;
         else               q1_n = sel_dir;
      end
      cnt_n = cnt_p + 2'(push);
   end

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         dir_r       <= DIR_RIGHT;
         q0          <= DIR_RIGHT;
         q1          <= DIR_RIGHT;
         cnt_q       <= '0;
         drop        <= 1'b0;
         dir_changed <= 1'b0;
      end else begin
         dir_r       <= dir_n;
         q0          <= q0_n;
         q1          <= q1_n;
         cnt_q       <= cnt_n;
         drop        <= drop_n;
         dir_changed <= pop && (q0 != dir_r);
      end
   end

   assign dir     = dir_r;
   assign q_count = cnt_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl: latency, rejection rules, queueing,
// tick/press collisions, simultaneous presses and reset behaviour.
module tb_snake_dir_ctrl;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic [3:0] KEY = 4'b1111;
   logic       tick = 1'b0;
   logic [1:0] dir;
   logic       dir_changed;
   logic [1:0] q_count;
   logic       drop;

   int checks = 0;
   int errors = 0;
   int drop_cnt = 0;
   int dc_cnt = 0;

   snake_dir_ctrl #(.DEBOUNCE_CYCLES(4), .KEY_ACTIVE_LOW(1)) dut (
      .CLOCK_50(clk), .Reset(Reset), .KEY(KEY), .tick(tick),
      .dir(dir), .dir_changed(dir_changed), .q_count(q_count), .drop(drop)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (drop) drop_cnt++;
      if (dir_changed) dc_cnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      Reset = 1'b1; KEY = 4'b1111; tick = 1'b0;
      cyc(2);
      Reset = 1'b0;
      cyc(1);
   endtask

   task automatic press(input logic [3:0] mask);
      KEY = ~mask;
      cyc(10);
      KEY = 4'b1111;
      cyc(10);
   endtask

   task automatic do_tick();
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; KEY = 4'b1111; tick = 1'b0;
      cyc(3);
      checks++; if (dir !== 2'b11) begin errors++; $display("FAIL reset_dir got %b exp 11", dir); end
      checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL reset_qcount got %0d exp 0", q_count); end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", drop); end
      checks++; if (dir_changed !== 1'b0) begin errors++; $display("FAIL reset_dirchg got %b exp 0", dir_changed); end
      Reset = 1'b0;
      cyc(1);
   endtask

   task automatic test_single_press();
      int d0, c0;
      do_reset();
      d0 = drop_cnt; c0 = dc_cnt;
      KEY = 4'b1011;
      cyc(7);
      checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL latency_early got %0d exp 0", q_count); end
      cyc(1);
      checks++; if (q_count !== 2'd1) begin errors++; $display("FAIL latency_exact got %0d exp 1", q_count); end
      cyc(2);
      KEY = 4'b1111;
      cyc(10);
      do_tick();
      checks++; if (dir !== 2'b00) begin errors++; $display("FAIL up_dir got %b exp 00", dir); end
      checks++; if (dir_changed !== 1'b1) begin errors++; $display("FAIL up_dirchg got %b exp 1", dir_changed); end
      checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL up_qcount got %0d exp 0", q_count); end
      cyc(1);
      checks++; if (dir_changed !== 1'b0) begin errors++; $display("FAIL up_dirchg_width got %b exp 0", dir_changed); end
      do_tick();
      checks++; if (dir !== 2'b00 || dc_cnt - c0 !== 1) begin errors++; $display("FAIL empty_tick dir %b exp 00 pulses %0d exp 1", dir, dc_cnt - c0); end
      checks++; if (drop_cnt - d0 !== 0) begin errors++; $display("FAIL up_nodrop got %0d exp 0", drop_cnt - d0); end
   endtask

   task automatic test_reject();
      int d0;
      do_reset();
      d0 = drop_cnt;
      press(4'b1000);
      checks++; if (drop_cnt - d0 !== 1) begin errors++; $display("FAIL reverse_drop got %0d exp 1", drop_cnt - d0); end
      checks++; if (q_count !== 2'd0 || dir !== 2'b11) begin errors++; $display("FAIL reverse_state q %0d dir %b exp q 0 dir 11", q_count, dir); end
      d0 = drop_cnt;
      press(4'b0001);
      checks++; if (drop_cnt - d0 !== 1) begin errors++; $display("FAIL dup_drop got %0d exp 1", drop_cnt - d0); end
   endtask

   task automatic test_glitch();
      int d0;
      do_reset();
      d0 = drop_cnt;
      KEY = 4'b1110;
      cyc(3);
      KEY = 4'b1111;
      cyc(12);
      checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL glitch_qcount got %0d exp 0", q_count); end
      checks++; if (drop_cnt - d0 !== 0) begin errors++; $display("FAIL glitch_drop got %0d exp 0", drop_cnt - d0); end
   endtask

   task automatic test_fifo_full();
      int d0, c0;
      do_reset();
      d0 = drop_cnt; c0 = dc_cnt;
      press(4'b0100);
      press(4'b1000);
      checks++; if (q_count !== 2'd2 || drop_cnt - d0 !== 0) begin errors++; $display("FAIL fill q %0d drops %0d exp q 2 drops 0", q_count, drop_cnt - d0); end
      press(4'b0010);
      checks++; if (q_count !== 2'd2 || drop_cnt - d0 !== 1) begin errors++; $display("FAIL full_drop q %0d drops %0d exp q 2 drops 1", q_count, drop_cnt - d0); end
      do_tick();
      checks++; if (dir !== 2'b00 || q_count !== 2'd1) begin errors++; $display("FAIL pop1 dir %b q %0d exp dir 00 q 1", dir, q_count); end
      do_tick();
      checks++; if (dir !== 2'b10 || q_count !== 2'd0) begin errors++; $display("FAIL pop2 dir %b q %0d exp dir 10 q 0", dir, q_count); end
      checks++; if (dc_cnt - c0 !== 2) begin errors++; $display("FAIL pop_pulses got %0d exp 2", dc_cnt - c0); end
   endtask

   task automatic test_back_to_back();
      int d0;
      do_reset();
      press(4'b0100);
      press(4'b1000);
      d0 = drop_cnt;
      KEY = 4'b1101;
      cyc(7);
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      checks++; if (dir !== 2'b00 || q_count !== 2'd2) begin errors++; $display("FAIL collide dir %b q %0d exp dir 00 q 2", dir, q_count); end
      cyc(1);
      KEY = 4'b1111;
      cyc(10);
      checks++; if (drop_cnt - d0 !== 0) begin errors++; $display("FAIL collide_drop got %0d exp 0", drop_cnt - d0); end
      do_tick();
      checks++; if (dir !== 2'b10) begin errors++; $display("FAIL collide_pop1 got %b exp 10", dir); end
      do_tick();
      checks++; if (dir !== 2'b01 || q_count !== 2'd0) begin errors++; $display("FAIL collide_pop2 dir %b q %0d exp dir 01 q 0", dir, q_count); end
   endtask

   task automatic test_simultaneous();
      int d0;
      do_reset();
      press(4'b0010);
      do_tick();
      checks++; if (dir !== 2'b01) begin errors++; $display("FAIL setup_down got %b exp 01", dir); end
      d0 = drop_cnt;
      press(4'b0101);
      checks++; if (q_count !== 2'd1 || drop_cnt - d0 !== 1) begin errors++; $display("FAIL simul q %0d drops %0d exp q 1 drops 1", q_count, drop_cnt - d0); end
      Reset = 1'b1;
      cyc(1);
      Reset = 1'b0;
      checks++; if (dir !== 2'b11 || q_count !== 2'd0) begin errors++; $display("FAIL reset_queue dir %b q %0d exp dir 11 q 0", dir, q_count); end
      cyc(2);
   endtask

   task automatic test_reset_held();
      do_reset();
      KEY = 4'b1011;
      cyc(4);
      Reset = 1'b1;
      cyc(2);
      Reset = 1'b0;
      cyc(7);
      checks++; if (q_count !== 2'd0) begin errors++; $display("FAIL held_early got %0d exp 0", q_count); end
      cyc(1);
      checks++; if (q_count !== 2'd1) begin errors++; $display("FAIL held_event got %0d exp 1", q_count); end
      KEY = 4'b1111;
      cyc(10);
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_reject();
      test_glitch();
      test_fifo_full();
      test_back_to_back();
      test_simultaneous();
      test_reset_held();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
